// File: rtl/ex_stage_pkg.sv
// Shared op codes, bus constants and mul/div FSM states for the execute stage.
// Pure definitions: no latency, no backpressure.
// Imported by ex_stage, ex_stage_muldiv and their bench.
package ex_stage_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SRL    = 5'd3;
    localparam logic [4:0] OP_SRA    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_XOR    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative radix-2 multiply / restoring divide on magnitudes with sign fix-up.
// Latency: 1 IDLE + MD_CYCLES BUSY cycles, result in DONE; busy high until then.
// No internal backpressure: caller must hold start/op/a/b stable while busy.
module ex_stage_muldiv
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int CW = $clog2(MD_CYCLES);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] a_raw_q, a_raw_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic            b_zero_q, b_zero_d;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;

    // MUL's low word is sign-agnostic, so treating it as signed is harmless.
    assign a_neg = a[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                                 op == OP_DIV || op == OP_REM);
    assign b_neg = b[XLEN-1] && (op == OP_MUL || op == OP_MULH ||
                                 op == OP_DIV || op == OP_REM);
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh   = {acc_q, lo_q[XLEN-1]};
    assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};

    assign prod     = {acc_q, lo_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        busy      = 1'b0;
        done      = 1'b0;
        res       = '0;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    op_d      = op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
                    lo_d      = is_mul_op(op) ? b_mag : a_mag;
                    opnd_d    = is_mul_op(op) ? a_mag : b_mag;
                    a_raw_d   = a;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (b == '0);
                    state_d   = MD_BUSY;
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (is_mul_op(op_q)) begin
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end else if (!div_diff[XLEN+1]) begin
                    acc_d = div_diff[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MD_CYCLES - 1)) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                done    = 1'b1;
                state_d = MD_IDLE;
                // INT_MIN / -1 needs no special path: magnitude 2^31 negated wraps to itself.
                unique case (op_q)
                    OP_MUL:                       res = prod_fix[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              res = b_zero_q ? '1 : quot_fix;
                    OP_REM, OP_REMU:              res = b_zero_q ? a_raw_q : rem_fix;
                    default:                      res = '0;
                endcase
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU plus iterative mul/div, combinational outputs.
// Latency: ALU 0 cycles; M ops stall 33 cycles, result on the 34th.
// Backpressure: stall_o holds upstream and feeds ex_mem a bubble while mul/div runs.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_i,
    input  logic            regwe_i,
    output logic            stall_o,
    output logic [4:0]      rd,
    output logic            regwe,
    output logic [XLEN-1:0] result
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            md_op;
    logic            md_busy, md_done;
    logic [XLEN-1:0] md_res;

    assign shamt = op2[4:0];
    assign md_op = is_md_op(alu_op);

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_SLL:  alu_res = op1 << shamt;
            OP_SRL:  alu_res = op1 >> shamt;
            OP_SRA:  alu_res = $signed(op1) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            OP_XOR:  alu_res = op1 ^ op2;
            OP_OR:   alu_res = op1 | op2;
            OP_AND:  alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

    ex_stage_muldiv #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_op && !rst),
        .op    (alu_op),
        .a     (op1),
        .b     (op2),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res)
    );

    always_comb begin
        stall_o = 1'b0;
        rd      = NOP_REG_ADDR;
        regwe   = 1'b0;
        result  = '0;
        if (!rst) begin
            if (md_op && md_done) begin
                rd     = rd_i;
                regwe  = regwe_i;
                result = md_res;
            end else if (md_op) begin
                stall_o = md_busy;
            end else begin
                rd     = rd_i;
                regwe  = regwe_i;
                result = alu_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, M-op latency/results, special cases, reset mid-op.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_op;
    logic [31:0] op1, op2;
    logic [4:0]  rd_i;
    logic        regwe_i;
    logic        stall_o;
    logic [4:0]  rd;
    logic        regwe;
    logic [31:0] result;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk     (clk),
        .rst     (rst),
        .alu_op  (alu_op),
        .op1     (op1),
        .op2     (op2),
        .rd_i    (rd_i),
        .regwe_i (regwe_i),
        .stall_o (stall_o),
        .rd      (rd),
        .regwe   (regwe),
        .result  (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdv, input logic we);
        alu_op  = op;
        op1     = a;
        op2     = b;
        rd_i    = rdv;
        regwe_i = we;
    endtask

    task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        @(posedge clk); #1;
        drive(op, a, b, 5'd9, 1'b1);
        @(negedge clk);
        check({tag, ".res"}, result, exp);
        check({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rdv, input logic we,
                          input logic [31:0] exp);
        int stalls;
        int bubble_bad;
        bit fin;
        @(posedge clk); #1;
        drive(op, a, b, rdv, we);
        stalls = 0;
        bubble_bad = 0;
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (stall_o) begin
                stalls++;
                if (regwe || rd != 5'd0 || result != 32'd0) bubble_bad++;
            end else begin
                fin = 1'b1;
            end
        end
        check({tag, ".stall_cycles"}, stalls, 33);
        check({tag, ".bubble"}, bubble_bad, 0);
        check({tag, ".res"}, result, exp);
        check({tag, ".rd"}, {27'd0, rd}, {27'd0, rdv});
        check({tag, ".regwe"}, {31'd0, regwe}, {31'd0, we});
    endtask

    initial begin
        rst = 1'b1;
        drive(OP_ADD, 32'd1, 32'd2, 5'd3, 1'b1);
        repeat (2) @(negedge clk);
        check("rst.stall", {31'd0, stall_o}, 32'd0);
        check("rst.rd", {27'd0, rd}, 32'd0);
        check("rst.regwe", {31'd0, regwe}, 32'd0);
        check("rst.res", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        @(posedge clk); #1;
        drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        @(negedge clk);
        check("add.res", result, 32'h8000_0000);
        check("add.rd", {27'd0, rd}, 32'd5);
        check("add.regwe", {31'd0, regwe}, 32'd1);
        check("add.stall", {31'd0, stall_o}, 32'd0);

        run_alu("sra",  OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        run_alu("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
        run_alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
        run_alu("sub",  OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
        run_alu("sll",  OP_SLL,  32'd1,         32'h0000_0021, 32'd2);
        run_alu("srl",  OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
        run_alu("xor",  OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_alu("or",   OP_OR,   32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0);
        run_alu("and",  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_alu("unk",  5'd31,   32'h1234_5678, 32'h1,         32'd0);

        run_md("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'd1);
        run_md("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'hFFFF_FFFE);
        run_md("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'd0);
        run_md("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFFF);
        run_md("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5, 1'b1, 32'hFFFF_FFFD);
        run_md("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 1'b1, 32'hFFFF_FFFF);
        run_md("divu",   OP_DIVU,   32'd100,       32'd7,         5'd7, 1'b1, 32'd14);
        run_md("remu",   OP_REMU,   32'd100,       32'd7,         5'd8, 1'b0, 32'd2);
        run_md("div0",   OP_DIV,    32'd5,         32'd0,         5'd9, 1'b1, 32'hFFFF_FFFF);
        run_md("rem0",   OP_REM,    32'd5,         32'd0,         5'd10, 1'b1, 32'd5);
        run_md("divu0",  OP_DIVU,   32'd5,         32'd0,         5'd11, 1'b1, 32'hFFFF_FFFF);
        run_md("remu0",  OP_REMU,   32'd5,         32'd0,         5'd12, 1'b1, 32'd5);
        run_md("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000);
        run_md("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0);
        run_md("mulneg", OP_MUL,    32'hFFFF_FFFD, 32'd7,         5'd15, 1'b1, 32'hFFFF_FFEB);

        // Reset lands in BUSY with the counter at 10.
        @(posedge clk); #1;
        drive(OP_DIV, 32'd1000, 32'd3, 5'd20, 1'b1);
        repeat (11) @(negedge clk);
        check("midrst.pre_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst.stall", {31'd0, stall_o}, 32'd0);
        check("midrst.res", result, 32'd0);
        check("midrst.regwe", {31'd0, regwe}, 32'd0);
        check("midrst.rd", {27'd0, rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(OP_ADD, 32'd2, 32'd3, 5'd7, 1'b1);
        @(negedge clk);
        check("postrst.stall", {31'd0, stall_o}, 32'd0);
        check("postrst.res", result, 32'd5);
        check("postrst.rd", {27'd0, rd}, 32'd7);
        check("postrst.regwe", {31'd0, regwe}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM core; sits between id_ex and ex_mem.
- Computes the RV32I ALU ops in a single cycle.
- Computes RV32M mul/div/rem ops with a fixed-latency iterative unit, stalling upstream while busy.
- Outputs rd/regwe/result are combinational; ex_mem registers them.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iteration count of the mul/div unit; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- alu_op  in  5  operation code, defined in define.vh
- op1  in  32  operand A (rs1 value or PC)
- op2  in  32  operand B (rs2 value or immediate)
- rd_i  in  5  destination register from id_ex
- regwe_i  in  1  write-enable from id_ex
- stall_o  out  1  high: id_ex and upstream stages must hold; ex_mem captures a bubble
- rd  out  5  destination to ex_mem
- regwe  out  1  write-enable to ex_mem
- result  out  32  result to ex_mem

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high.
- While rst=1: rd=0 (`NopRegAddr), regwe=0, result=0, stall_o=0. FSM goes to IDLE, counter=0.
- ALU ops (ADD SUB SLL SRL SRA SLT SLTU XOR OR AND):
  - Combinational, 0 extra latency, stall_o=0.
  - Shift amount is op2[4:0].
  - SLT is signed; SLTU is unsigned.
  - rd=rd_i, regwe=regwe_i.
- M ops (MUL MULH MULHSU MULHU DIV DIVU REM REMU) use an FSM with states IDLE, BUSY, DONE.
- IDLE with an M op:
  - stall_o=1; latch operands, op and sign info; clear counter; next state BUSY.
  - Operands are converted to magnitudes:
    - signed ops take abs of signed operands;
    - MULHSU treats only op1 as signed;
    - unsigned ops pass operands through unchanged.
- BUSY:
  - stall_o=1.
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments 0..31; when counter=31, next state is DONE.
- DONE:
  - stall_o=0; result valid; rd=rd_i, regwe=regwe_i; next state IDLE.
  - Upstream advances at the end of this cycle. DONE never restarts on the still-present M op.
- While stall_o=1: regwe=0 and rd=0, so ex_mem latches a bubble. result is don't-care, driven 0.
- Timing: stall_o is high for exactly 33 cycles (1 IDLE + 32 BUSY). The result appears on cycle 34.
- Sign fix-up (DONE):
  - Product: 64-bit magnitude, negated if sign(a)^sign(b) for signed forms.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend.
- Special cases (same fixed latency, no short-circuit):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed overflow 0x80000000 / -1: DIV gives 0x80000000; REM gives 0.
- Reset mid-operation: the next cycle is IDLE with stall_o=0. The partial result is discarded.
- regwe_i=0 with an M op still runs the full latency; regwe stays 0 in DONE.
- Unknown alu_op: result=0, regwe=regwe_i, no stall.

Decomposition:
- Shared in define.vh:
  - `AluOpBus [4:0] and all 18 op codes;
  - `RegBus [31:0], `RegAddrBus [4:0];
  - `Enabled, `Disabled, `Zero, `NopRegAddr;
  - state encodings MD_IDLE, MD_BUSY, MD_DONE.
- Sub-module muldiv:
  - Iterative unit with the FSM, counter, magnitude/sign logic and special cases.
  - Ports: clk, rst, start, op, a, b, busy, done, res.
- ex_stage holds the ALU, the muldiv instance and the output mux/stall logic.

Test Plan:
- ADD op1=0x7FFFFFFF, op2=1, rd_i=5, regwe_i=1 -> same cycle: result=0x80000000, rd=5, regwe=1, stall_o=0.
- SRA op1=0x80000000, op2=0x24 -> result=0xF8000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0.
- MUL 0xFFFFFFFF*0xFFFFFFFF (inputs held) -> stall_o high 33 cycles, regwe=0 throughout; cycle 34: MUL=1, MULHU=0xFFFFFFFE, MULH=0, MULHSU=0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; all at cycle 34.
- DIV/REM 5/0 -> 0xFFFFFFFF / 5; DIV/REM 0x80000000/0xFFFFFFFF -> 0x80000000 / 0; same 34-cycle latency.
- Assert rst at BUSY cycle 10 -> next cycle stall_o=0, outputs 0. A following ADD 2+3 gives 5 with no stall.
